// File: rtl/melody_seq.sv
// ---------------------------------------------------------------------------
// melody_seq -- note sequencer that sits directly upstream of the io_bz buzzer
// controller. A melody of 8-bit note codes {dur[7:4], pitch[3:0]} is written
// one entry at a time and then played back. Each note is presented to io_bz
// as a one-cycle bz_start pulse together with a bz_val that stays stable for
// the whole note. A silent gap separates consecutive notes.
//
// Timing: one tick is TICK_DIV clk cycles (0.1 s at 10 MHz with the default).
// A note with duration code n lasts (n+1) ticks. Those ticks are counted from
// the START cycle. GAP_TICKS silent ticks follow each note. When GAP_TICKS is
// 0, the gap is a single pass-through cycle.
//
// Optional feature macro: MELODY_LOOP_EN
//   defined   : the loop port exists. When loop=1 at the end of the melody,
//               playback restarts seamlessly at entry 0.
//   undefined : the loop port is absent. Playback always stops at the end.
//
// Ports
//   clk       in   1     system clock
//   rst       in   1     asynchronous, active-low reset
//   wr_en     in   1     append wr_data to the melody (1-cycle strobe)
//   wr_data   in   8     note code {dur, pitch}; pitch 0 is a rest
//   clr       in   1     stop playback and empty the melody
//   play      in   1     start playback from entry 0 (1-cycle strobe)
//   stop      in   1     abort playback
//   loop      in   1     repeat the melody at its end (MELODY_LOOP_EN only)
//   bz_start  out  1     to io_bz.start, 1-cycle pulse per note
//   bz_val    out  8     to io_bz.val, held for the whole note
//   busy      out  1     high while a melody is being played
//   full      out  1     count == DEPTH
//   count     out  AW+1  number of stored entries
//   idx       out  AW    entry currently playing
// ---------------------------------------------------------------------------
module melody_seq #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int GAP_TICKS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic          play,
  input  logic          stop,
`ifdef MELODY_LOOP_EN
  input  logic          loop,
`endif
  output logic          bz_start,
  output logic [7:0]    bz_val,
  output logic          busy,
  output logic          full,
  output logic [AW:0]   count,
  output logic [AW-1:0] idx
);

  // Cycle counter width. Keep at least one bit so that TICK_DIV=1 still elaborates.
  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CYC_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [4:0]    GAP_LAST  = (GAP_TICKS > 0) ? 5'(GAP_TICKS - 1) : 5'd0;
  localparam bit            GAP_NONE  = (GAP_TICKS == 0);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = {(AW + 1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            bz_start_q, bz_start_d;
  logic [7:0]      bz_val_q, bz_val_d;
  logic            busy_q, busy_d;
  logic            full_q, full_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [4:0]      tick_q, tick_d;

  logic [7:0]      mem_q [DEPTH];
  logic            mem_we;

  logic            cyc_wrap;
  logic            note_end;
  logic            gap_end;
  logic            has_next;
  logic            loop_en;
  logic [CW-1:0]   cyc_inc;
  logic [4:0]      tick_inc;

`ifdef MELODY_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Free-running tick arithmetic shared by the START/PLAY/GAP states.
  assign cyc_wrap = (cyc_q == CYC_LAST);
  assign cyc_inc  = cyc_wrap ? CYC_ZERO : (cyc_q + CYC_ONE);
  assign tick_inc = cyc_wrap ? (tick_q + 5'd1) : tick_q;

  // The note ends on the last cycle of tick number dur. Counting starts at START,
  // so the sounding part of the note spans (dur+1)*TICK_DIV cycles in total.
  assign note_end = cyc_wrap && (tick_q == {1'b0, bz_val_q[7:4]});
  assign gap_end  = GAP_NONE ? 1'b1 : (cyc_wrap && (tick_q == GAP_LAST));

  // More entries remain in this pass when idx+1 < count.
  assign has_next = (({1'b0, idx_q} + CNT_ONE) < count_q);

  // Next-state, output and datapath decisions, applied in priority order clr > stop > play > wr_en.
  always_comb begin
    state_d    = state_q;
    bz_start_d = 1'b0;
    bz_val_d   = bz_val_q;
    count_d    = count_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    tick_d     = tick_q;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play && (count_q != CNT_ZERO)) begin
          state_d = S_LOAD;
          idx_d   = IDX_ZERO;
        end else if (wr_en && !full_q) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        cyc_d      = CYC_ZERO;
        tick_d     = 5'd0;
        bz_val_d   = mem_q[idx_q];
        bz_start_d = 1'b1;
        state_d    = S_START;
      end

      // START and PLAY share the note-duration count. START normally lasts one
      // cycle. With a one-cycle note, it can also finish the note itself.
      S_START, S_PLAY: begin
        cyc_d  = cyc_inc;
        tick_d = tick_inc;
        if (note_end) begin
          state_d  = S_GAP;
          cyc_d    = CYC_ZERO;
          tick_d   = 5'd0;
          bz_val_d = {bz_val_q[7:4], 4'h0};
        end else begin
          state_d = S_PLAY;
        end
      end

      S_GAP: begin
        cyc_d  = cyc_inc;
        tick_d = tick_inc;
        if (gap_end) begin
          if (has_next) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end else if (loop_en) begin
            idx_d   = IDX_ZERO;
            state_d = S_LOAD;
          end else begin
            idx_d    = IDX_ZERO;
            bz_val_d = 8'h00;
            state_d  = S_IDLE;
          end
        end else begin
          state_d = S_GAP;
        end
      end

      default: begin
        state_d  = S_IDLE;
        bz_val_d = 8'h00;
        idx_d    = IDX_ZERO;
      end
    endcase

    // stop silences io_bz (pitch 0). It leaves idx alone so the abort point stays visible.
    if (stop && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      bz_val_d   = 8'h00;
      bz_start_d = 1'b0;
      idx_d      = idx_q;
      cyc_d      = CYC_ZERO;
      tick_d     = 5'd0;
      mem_we     = 1'b0;
    end else begin
      mem_we     = mem_we;
    end

    // clr overrides everything else, including a play or a write in the same cycle.
    if (clr) begin
      state_d    = S_IDLE;
      bz_val_d   = 8'h00;
      bz_start_d = 1'b0;
      count_d    = CNT_ZERO;
      idx_d      = IDX_ZERO;
      cyc_d      = CYC_ZERO;
      tick_d     = 5'd0;
      mem_we     = 1'b0;
    end else begin
      count_d    = count_d;
    end

    busy_d = (state_d != S_IDLE);
    full_d = (count_d == DEPTH_C);
  end

  // Control and output registers. The asynchronous reset puts every output at its idle value at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bz_start_q <= 1'b0;
      bz_val_q   <= 8'h00;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      count_q    <= CNT_ZERO;
      idx_q      <= IDX_ZERO;
      cyc_q      <= CYC_ZERO;
      tick_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      bz_start_q <= bz_start_d;
      bz_val_q   <= bz_val_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      tick_q     <= tick_d;
    end
  end

  // Melody storage. It is not reset: count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[AW-1:0]] <= wr_data;
    end
  end

  assign bz_start = bz_start_q;
  assign bz_val   = bz_val_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign count    = count_q;
  assign idx      = idx_q;

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq (TICK_DIV=4, GAP_TICKS=1, DEPTH=16).
// The reference model builds the expected per-cycle waveform of a melody
// directly from the note list and the timing rules of a note, its gap and
// the load cycle.
module tb_melody_seq;

  localparam int TD    = 4;
  localparam int GT    = 1;
  localparam int GAPC  = (GT == 0) ? 1 : GT * TD;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr;
  logic       play;
  logic       stop;
`ifdef MELODY_LOOP_EN
  logic       loop;
`endif
  logic       bz_start;
  logic [7:0] bz_val;
  logic       busy;
  logic       full;
  logic [4:0] count;
  logic [3:0] idx;

  melody_seq #(
    .DEPTH(DEPTH), .AW(4), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .play(play), .stop(stop),
`ifdef MELODY_LOOP_EN
    .loop(loop),
`endif
    .bz_start(bz_start), .bz_val(bz_val), .busy(busy), .full(full),
    .count(count), .idx(idx)
  );

  int n_checks;
  int n_fail;

  logic [7:0] notes [0:31];
  logic       exp_busy  [0:2047];
  logic       exp_start [0:2047];
  logic [7:0] exp_val   [0:2047];
  logic [3:0] exp_idx   [0:2047];
  int         exp_len;
  int         drop_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_note(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Expected waveform for notes[0..n-1] played reps times. Sample t is the
  // state after the t-th clock edge, counting the edge that samples play as 1.
  task automatic build_expect(input int n, input int reps);
    int t;
    int k;
    logic [7:0] nt;
    t = 1;
    drop_t = -1;
    exp_busy[t] = 1'b1; exp_start[t] = 1'b0; exp_val[t] = 8'h00; exp_idx[t] = 4'd0;
    t++;
    for (int i = 0; i < n * reps; i++) begin
      k  = i % n;
      nt = notes[k];
      if (reps > 1 && i == n * (reps - 1)) drop_t = t + 1;
      for (int c = 0; c < (int'(nt[7:4]) + 1) * TD; c++) begin
        exp_busy[t] = 1'b1; exp_start[t] = (c == 0); exp_val[t] = nt; exp_idx[t] = 4'(k);
        t++;
      end
      for (int c = 0; c < GAPC; c++) begin
        exp_busy[t] = 1'b1; exp_start[t] = 1'b0; exp_val[t] = {nt[7:4], 4'h0}; exp_idx[t] = 4'(k);
        t++;
      end
      if (i < n * reps - 1) begin
        exp_busy[t] = 1'b1; exp_start[t] = 1'b0; exp_val[t] = {nt[7:4], 4'h0};
        exp_idx[t] = 4'((i + 1) % n);
        t++;
      end
    end
    exp_busy[t] = 1'b0; exp_start[t] = 1'b0; exp_val[t] = 8'h00; exp_idx[t] = 4'd0;
    exp_len = t;
  endtask

  // Plays the melody and compares {busy, bz_start, bz_val, idx} against the model
  // on every cycle up to upto (0 = whole melody). With wr_noise set, random writes are attempted throughout playback.
  task automatic run_play(input string name, input int n, input int reps, input bit wr_noise, input int upto);
    int last;
    build_expect(n, reps);
    last = (upto > 0) ? upto : exp_len;
`ifdef MELODY_LOOP_EN
    loop = (reps > 1);
`endif
    play = 1'b1;
    step();
    play = 1'b0;
    for (int t = 1; t <= last; t++) begin
      if (t > 1) begin
        if (wr_noise) begin
          wr_en = 1'($urandom_range(0, 1));
          wr_data = 8'($urandom);
        end
`ifdef MELODY_LOOP_EN
        if (t == drop_t) loop = 1'b0;
`endif
        step();
      end
      n_checks++;
      if ({busy, bz_start, bz_val, idx} !== {exp_busy[t], exp_start[t], exp_val[t], exp_idx[t]}) begin
        n_fail++;
        if (n_fail < 25)
          $display("FAIL %s cycle %0d: busy/start/val/idx got %b/%b/%h/%0d expected %b/%b/%h/%0d",
                   name, t, busy, bz_start, bz_val, idx, exp_busy[t], exp_start[t], exp_val[t], exp_idx[t]);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bz_start, bz_val, busy, full, count, idx} !== {1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state: start/val/busy/full/count/idx got %b/%h/%b/%b/%0d/%0d expected 0/00/0/0/0/0",
               bz_start, bz_val, busy, full, count, idx);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_three_notes();
    do_clr();
    notes[0] = 8'h01; notes[1] = 8'h15; notes[2] = 8'h03;
    for (int i = 0; i < 3; i++) wr_note(notes[i]);
    run_play("three_notes", 3, 1, 1'b0, 0);
    n_checks++;
    if ({count, bz_val, busy} !== {5'd3, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL three_notes_end: count/val/busy got %0d/%h/%b expected 3/00/0", count, bz_val, busy);
    end
  endtask

  task automatic test_random_melodies();
    int n;
    for (int it = 0; it < 4; it++) begin
      do_clr();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        notes[i] = {4'($urandom_range(0, 3)), 4'($urandom)};
        wr_note(notes[i]);
      end
      n_checks++;
      if (count !== 5'(n)) begin
        n_fail++;
        $display("FAIL random_count: got %0d expected %0d", count, n);
      end
      run_play("random_play", n, 1, 1'b0, 0);
      // The melody is retained after playback and can be played again.
      if (it == 3) run_play("random_replay", n, 1, 1'b0, 0);
    end
  endtask

  task automatic test_full();
    do_clr();
    for (int i = 0; i < 17; i++) begin
      notes[i] = {4'($urandom_range(0, 1)), 4'($urandom)};
      wr_note(notes[i]);
      n_checks++;
      if ({full, count} !== {(i + 1 >= DEPTH), 5'((i + 1 >= DEPTH) ? DEPTH : i + 1)}) begin
        n_fail++;
        $display("FAIL full_fill write %0d: full/count got %b/%0d expected %b/%0d", i, full, count,
                 (i + 1 >= DEPTH), (i + 1 >= DEPTH) ? DEPTH : i + 1);
      end
    end
    run_play("full_play_wr_noise", DEPTH, 1, 1'b1, 0);
    n_checks++;
    if ({full, count} !== {1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL full_after_play: full/count got %b/%0d expected 1/16", full, count);
    end
  endtask

  task automatic test_play_empty();
    int bad;
    do_clr();
    bad = 0;
    play = 1'b1;
    step();
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy || bz_start) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL play_empty: active cycles got %0d expected 0", bad);
    end
  endtask

  task automatic test_stop();
    do_clr();
    notes[0] = 8'h01; notes[1] = 8'h15; notes[2] = 8'h03;
    for (int i = 0; i < 3; i++) wr_note(notes[i]);
    // Note 2 starts at cycle 11 and sounds for 8 cycles; cycle 13 is inside it.
    run_play("stop_prefix", 3, 1, 1'b0, 13);
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if ({busy, bz_start, bz_val, idx} !== {1'b0, 1'b0, 8'h00, 4'd1}) begin
      n_fail++;
      $display("FAIL stop_abort: busy/start/val/idx got %b/%b/%h/%0d expected 0/0/00/1", busy, bz_start, bz_val, idx);
    end
    repeat (4) step();
    n_checks++;
    if ({busy, bz_start, count} !== {1'b0, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL stop_stays_idle: busy/start/count got %b/%b/%0d expected 0/0/3", busy, bz_start, count);
    end
  endtask

  task automatic test_clr_play();
    int bad;
    do_clr();
    wr_note(8'h12);
    wr_note(8'h24);
    clr = 1'b1;
    play = 1'b1;
    step();
    clr = 1'b0;
    play = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy || bz_start) bad++;
      step();
    end
    n_checks++;
    if ({count, busy, full} !== {5'd0, 1'b0, 1'b0} || bad !== 0) begin
      n_fail++;
      $display("FAIL clr_play: count/busy/active got %0d/%b/%0d expected 0/0/0", count, busy, bad);
    end
  endtask

`ifdef MELODY_LOOP_EN
  task automatic test_loop();
    do_clr();
    notes[0] = 8'h01; notes[1] = 8'h15;
    wr_note(notes[0]);
    wr_note(notes[1]);
    run_play("loop_play", 2, 3, 1'b0, 0);
  endtask
`endif

  task automatic test_reset_mid_play();
    do_clr();
    notes[0] = 8'h21; notes[1] = 8'h13; notes[2] = 8'h05;
    for (int i = 0; i < 3; i++) wr_note(notes[i]);
    run_play("reset_prefix", 3, 1, 1'b0, 7);
    // Reset is applied between clock edges. The outputs must clear without an edge.
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bz_start, bz_val, busy, full, count, idx} !== {1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_play: start/val/busy/full/count/idx got %b/%h/%b/%b/%0d/%0d expected 0/00/0/0/0/0",
               bz_start, bz_val, busy, full, count, idx);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr = 1'b0;
    play = 1'b0;
    stop = 1'b0;
`ifdef MELODY_LOOP_EN
    loop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_three_notes();
    test_random_melodies();
    test_full();
    test_play_empty();
    test_stop();
    test_clr_play();
`ifdef MELODY_LOOP_EN
    test_loop();
`endif
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
